// File: rtl/term_ctrl_pkg.sv
// Shared constants for the terminal byte front end:
// control codes, write types and FSM state encodings.
package term_ctrl_pkg;

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_ESC = 8'h1B;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_Y   = 8'h59;
  localparam logic [7:0] CH_DEL = 8'h7F;

  localparam logic [1:0] DT_CHAR = 2'd0;
  localparam logic [1:0] DT_COL  = 2'd1;
  localparam logic [1:0] DT_ROW  = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ESC,
    ST_ESC_R,
    ST_ESC_C,
    ST_CLR_C,
    ST_CLR_R,
    ST_CLR_FILL,
    ST_WR1,
    ST_WR2
  } state_e;

  typedef enum logic [1:0] {
    SB_IDLE,
    SB_SETUP,
    SB_STROBE,
    SB_HOLD
  } sb_state_e;

endpackage

// File: rtl/term_ctrl_strobe.sv
// Write-port sequencer: SETUP -> STROBE x STB_W -> HOLD.
// Ports: start/data/dtype in; vc_* to terminal, done high on HOLD.
module term_ctrl_strobe
  import term_ctrl_pkg::*;
#(
  parameter int STB_W = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  input  logic [1:0] dtype,
  output logic [7:0] vc_data,
  output logic       vc_dstrobe,
  output logic [1:0] vc_dtype,
  output logic       done
);

  localparam int CW = (STB_W > 1) ? $clog2(STB_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STB_W - 1);

  sb_state_e     st_q;
  logic [CW-1:0] cnt_q;

  assign done = (st_q == SB_HOLD);

  // start is only honoured from IDLE or HOLD, so a chained
  // write goes HOLD -> SETUP with no idle cycle between.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q       <= SB_IDLE;
      cnt_q      <= '0;
      vc_data    <= 8'h00;
      vc_dtype   <= DT_CHAR;
      vc_dstrobe <= 1'b0;
    end else begin
      unique case (st_q)
        SB_IDLE, SB_HOLD: begin
          if (start) begin
            st_q     <= SB_SETUP;
            vc_data  <= data;
            vc_dtype <= dtype;
          end else begin
            st_q <= SB_IDLE;
          end
        end
        SB_SETUP: begin
          st_q       <= SB_STROBE;
          vc_dstrobe <= 1'b1;
          cnt_q      <= '0;
        end
        SB_STROBE: begin
          if (cnt_q == CNT_LAST) begin
            st_q       <= SB_HOLD;
            vc_dstrobe <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: st_q <= SB_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/term_ctrl.sv
// Byte-stream front end: decodes bytes/ESC-Y, sequences writes.
// Ports: in_* handshake, busy, vc_* write port, cur_row/cur_col.
module term_ctrl
  import term_ctrl_pkg::*;
#(
  parameter int         COLS     = 80,
  parameter int         ROWS     = 30,
  parameter int         STB_W    = 1,
  parameter logic [7:0] CLR_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic [7:0] vc_data,
  output logic       vc_dstrobe,
  output logic [1:0] vc_dtype,
  output logic [5:0] cur_row,
  output logic [6:0] cur_col
);

  localparam logic [6:0]  COL_MAX = 7'(COLS - 1);
  localparam logic [5:0]  ROW_MAX = 6'(ROWS - 1);
  localparam logic [11:0] CNT_MAX = 12'(COLS * ROWS - 1);

  state_e      state_q, state_d;
  logic [5:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [5:0]  esc_r_q, esc_r_d;
  logic [7:0]  pend_data_q, pend_data_d;
  logic [1:0]  pend_dtype_q, pend_dtype_d;
  logic        go_q, go_d;
  logic [11:0] cnt_q, cnt_d;

  logic       start;
  logic [7:0] st_data;
  logic [1:0] st_dtype;
  logic       done;
  logic       accept;
  logic [5:0] row_nxt;
  logic [7:0] arg;
  logic [5:0] r_arg;
  logic [6:0] c_arg;
  logic       is_print;

  assign in_ready = (state_q == ST_IDLE) ||
                    (state_q == ST_ESC) ||
                    (state_q == ST_ESC_R) ||
                    (state_q == ST_ESC_C);
  assign busy     = ~in_ready;
  assign accept   = in_valid & in_ready;
  assign cur_row  = row_q;
  assign cur_col  = col_q;

  assign row_nxt  = (row_q == ROW_MAX) ? 6'd0 : row_q + 6'd1;
  assign is_print = (in_data >= CH_SP) && (in_data != CH_DEL);

  // ESC-Y arguments: offset by 0x20, low bytes pin to 0,
  // high bytes clamp to the last row/column.
  assign arg   = in_data - CH_SP;
  assign r_arg = (in_data < CH_SP) ? 6'd0 :
                 (arg > {2'b00, ROW_MAX}) ? ROW_MAX :
                 arg[5:0];
  assign c_arg = (in_data < CH_SP) ? 7'd0 :
                 (arg > {1'b0, COL_MAX}) ? COL_MAX :
                 arg[6:0];

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    esc_r_d      = esc_r_q;
    pend_data_d  = pend_data_q;
    pend_dtype_d = pend_dtype_q;
    go_d         = 1'b0;
    cnt_d        = cnt_q;
    start        = go_q;
    st_data      = pend_data_q;
    st_dtype     = pend_dtype_q;

    // Mirror follows whatever write just reached HOLD.
    if (done) begin
      unique case (vc_dtype)
        DT_COL: col_d = vc_data[6:0];
        DT_ROW: row_d = vc_data[5:0];
        default: begin
          if (col_q == COL_MAX) begin
            col_d = 7'd0;
            row_d = row_nxt;
          end else begin
            col_d = col_q + 7'd1;
          end
        end
      endcase
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            (in_data == CH_CR): begin
              pend_data_d  = 8'h00;
              pend_dtype_d = DT_COL;
              state_d      = ST_WR2;
              go_d         = 1'b1;
            end
            (in_data == CH_LF): begin
              pend_data_d  = {2'b00, row_nxt};
              pend_dtype_d = DT_ROW;
              state_d      = ST_WR2;
              go_d         = 1'b1;
            end
            (in_data == CH_BS): begin
              if (col_q != 7'd0) begin
                pend_data_d  = {1'b0, col_q - 7'd1};
                pend_dtype_d = DT_COL;
                state_d      = ST_WR2;
                go_d         = 1'b1;
              end
            end
            (in_data == CH_FF): begin
              pend_data_d  = 8'h00;
              pend_dtype_d = DT_COL;
              state_d      = ST_CLR_C;
              go_d         = 1'b1;
            end
            (in_data == CH_ESC): state_d = ST_ESC;
            is_print: begin
              pend_data_d  = in_data;
              pend_dtype_d = DT_CHAR;
              state_d      = ST_WR2;
              go_d         = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_ESC: begin
        if (accept)
          state_d = (in_data == CH_Y) ? ST_ESC_R : ST_IDLE;
      end
      ST_ESC_R: begin
        if (accept) begin
          esc_r_d = r_arg;
          state_d = ST_ESC_C;
        end
      end
      ST_ESC_C: begin
        if (accept) begin
          pend_data_d  = {1'b0, c_arg};
          pend_dtype_d = DT_COL;
          state_d      = ST_WR1;
          go_d         = 1'b1;
        end
      end
      ST_WR1: begin
        if (done) begin
          start    = 1'b1;
          st_data  = {2'b00, esc_r_q};
          st_dtype = DT_ROW;
          state_d  = ST_WR2;
        end
      end
      ST_WR2: begin
        if (done) state_d = ST_IDLE;
      end
      ST_CLR_C: begin
        if (done) begin
          start    = 1'b1;
          st_data  = 8'h00;
          st_dtype = DT_ROW;
          state_d  = ST_CLR_R;
        end
      end
      ST_CLR_R: begin
        if (done) begin
          start    = 1'b1;
          st_data  = CLR_CHAR;
          st_dtype = DT_CHAR;
          cnt_d    = 12'd0;
          state_d  = ST_CLR_FILL;
        end
      end
      ST_CLR_FILL: begin
        if (done) begin
          if (cnt_q == CNT_MAX) begin
            state_d = ST_IDLE;
          end else begin
            start    = 1'b1;
            st_data  = CLR_CHAR;
            st_dtype = DT_CHAR;
            cnt_d    = cnt_q + 12'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      row_q        <= 6'd0;
      col_q        <= 7'd0;
      esc_r_q      <= 6'd0;
      pend_data_q  <= 8'h00;
      pend_dtype_q <= DT_CHAR;
      go_q         <= 1'b0;
      cnt_q        <= 12'd0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      esc_r_q      <= esc_r_d;
      pend_data_q  <= pend_data_d;
      pend_dtype_q <= pend_dtype_d;
      go_q         <= go_d;
      cnt_q        <= cnt_d;
    end
  end

  term_ctrl_strobe #(
    .STB_W(STB_W)
  ) u_strobe (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data      (st_data),
    .dtype     (st_dtype),
    .vc_data   (vc_data),
    .vc_dstrobe(vc_dstrobe),
    .vc_dtype  (vc_dtype),
    .done      (done)
  );

endmodule
